cart_sram_arbiter: RTL and testbench

Sequencer and arbiter for the cartridge bus when accessing battery-backed SRAM on an MBC cartridge. It shares the bus between two requesters: port 0 is the save-dump read path and port 1 is the save-restore write path. For each request it performs any RAM-enable and bank-select writes the cartridge needs, then the SRAM access itself. It sits between the bridge-facing save logic and the cart_tran pins, and it is the only block that drives the cart bus during save operations.

---
 rtl/cart_bus_pkg.sv | 31 +++
 rtl/cart_sram_arbiter_if.sv | 28 ++
 rtl/cart_bus_cycle.sv | 72 +++++++
 rtl/cart_sram_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cart_sram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_bus_pkg.sv
// Shared constants, strobe encoding and state types for the cartridge SRAM bus sequencer.
package cart_bus_pkg;

  localparam logic [15:0] RAM_ENABLE_ADDR  = 16'h0000;
  localparam logic [7:0]  RAM_ENABLE_VAL   = 8'h0A;
  localparam logic [7:0]  RAM_DISABLE_VAL  = 8'h00;
  localparam logic [15:0] BANK_SELECT_ADDR = 16'h4000;
  localparam logic [15:0] SRAM_BASE        = 16'hA000;

  // Pin-level bank0 nibble: {unused, /WR, /RD, CS}
  function automatic logic [3:0] bank0_strobes(input logic wr, input logic rd, input logic cs);
    return {1'b0, ~wr, ~rd, cs};
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REL,
    ST_EN,
    ST_BANK,
    ST_ACC,
    ST_DONE
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_t;

endpackage

// File: rtl/cart_sram_arbiter_if.sv
// Requester-side handshake bundle between the save logic and the SRAM arbiter.
interface cart_sram_arbiter_if #(
  parameter int BANK_BITS = 4
);
  localparam int AW = 13 + BANK_BITS;

  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [7:0]    wdata0;
  logic [7:0]    wdata1;
  logic [1:0]    ack;
  logic [7:0]    rdata;
  logic          busy;
  logic          release_req;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1, release_req,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1, release_req,
    output ack, rdata, busy
  );

endinterface

// File: rtl/cart_bus_cycle.sv
// One cartridge bus cycle: SETUP (1) + STROBE (len) + HOLD (1), with read capture on the last strobe.
module cart_bus_cycle
  import cart_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [15:0] len,
  input  logic [7:0]  data_in,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [15:0] cart_address,
  output logic [3:0]  bank0_out,
  output logic [7:0]  data_out,
  output logic        dir
);

  phase_t      phase;
  logic [15:0] cnt;
  logic        we_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= PH_IDLE;
      cnt          <= '0;
      we_q         <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      cart_address <= '0;
      bank0_out    <= bank0_strobes(1'b0, 1'b0, 1'b0);
      data_out     <= '0;
      dir          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (phase)
        // A start accepted in HOLD chains the next cycle with no idle gap
        PH_IDLE, PH_HOLD: begin
          if (start) begin
            phase        <= PH_SETUP;
            cart_address <= addr;
            we_q         <= we;
            dir          <= we;
            cnt          <= len - 16'd1;
            if (we) data_out <= wdata;
          end else begin
            phase <= PH_IDLE;
            dir   <= 1'b0;
          end
        end
        PH_SETUP: begin
          phase     <= PH_STROBE;
          bank0_out <= bank0_strobes(we_q, ~we_q, we_q);
        end
        PH_STROBE: begin
          if (cnt == '0) begin
            phase     <= PH_HOLD;
            bank0_out <= bank0_strobes(1'b0, 1'b0, 1'b0);
            done      <= 1'b1;
            if (!we_q) rdata <= data_in;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: phase <= PH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cart_sram_arbiter.sv
// Two-port arbiter and sequencer for battery-backed MBC SRAM: RAM enable, bank select, access, release.
module cart_sram_arbiter
  import cart_bus_pkg::*;
#(
  parameter int READ_CYCLES  = 16,
  parameter int WRITE_CYCLES = 64,
  parameter int BANK_BITS    = 4
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  cart_sram_arbiter_if.slave    sram,
  output logic [15:0]           cart_address,
  output logic [7:4]            cart_tran_bank0_out,
  input  logic [7:0]            cart_tran_bank1_in,
  output logic [7:0]            cart_tran_bank1_out,
  output logic                  cart_tran_bank1_dir
);

  localparam int          AW     = 13 + BANK_BITS;
  localparam logic [15:0] RD_LEN = 16'(READ_CYCLES);
  localparam logic [15:0] WR_LEN = 16'(WRITE_CYCLES);

  seq_state_t           state;
  logic                 ram_enabled;
  logic                 bank_valid;
  logic [BANK_BITS-1:0] current_bank;
  logic                 last_grant;
  logic                 release_pending;
  logic                 port_q;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [7:0]           wdata_q;

  logic                 grant_port;
  logic                 cur_we;
  logic [AW-1:0]        cur_addr;
  logic [7:0]           cur_wdata;
  logic [BANK_BITS-1:0] cur_bank;
  logic [12:0]          cur_offset;
  logic                 launch_valid;
  seq_state_t           launch;
  logic [15:0]          cyc_addr;
  logic [7:0]           cyc_data;
  logic                 cyc_we;
  logic [15:0]          cyc_len;
  logic                 cyc_done;
  logic [7:0]           cyc_rdata;
  logic [3:0]           bank0_nib;

  function automatic seq_state_t pick_step(input logic en, input logic bv,
                                           input logic [BANK_BITS-1:0] cur,
                                           input logic [BANK_BITS-1:0] bank);
    if (!en) return ST_EN;
    else if (!bv || bank != cur) return ST_BANK;
    else return ST_ACC;
  endfunction

  // In IDLE the request fields come straight from the winning port so the first step starts at once
  always_comb begin
    if (sram.req == 2'b11) grant_port = ~last_grant;
    else                   grant_port = sram.req[1];
    if (state == ST_IDLE) begin
      cur_we    = grant_port ? sram.we[1]  : sram.we[0];
      cur_addr  = grant_port ? sram.addr1  : sram.addr0;
      cur_wdata = grant_port ? sram.wdata1 : sram.wdata0;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign cur_bank   = cur_addr[AW-1:13];
  assign cur_offset = cur_addr[12:0];

  always_comb begin
    launch_valid = 1'b0;
    launch       = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (release_pending) begin
          launch_valid = 1'b1;
          launch       = ST_REL;
        end else if (|sram.req) begin
          launch_valid = 1'b1;
          launch       = pick_step(ram_enabled, bank_valid, current_bank, cur_bank);
        end
      end
      ST_EN: begin
        if (cyc_done) begin
          launch_valid = 1'b1;
          launch       = pick_step(1'b1, bank_valid, current_bank, cur_bank);
        end
      end
      ST_BANK: begin
        if (cyc_done) begin
          launch_valid = 1'b1;
          launch       = ST_ACC;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cyc_addr = RAM_ENABLE_ADDR;
    cyc_data = RAM_DISABLE_VAL;
    cyc_we   = 1'b1;
    cyc_len  = WR_LEN;
    case (launch)
      ST_EN:   cyc_data = RAM_ENABLE_VAL;
      ST_BANK: begin
        cyc_addr = BANK_SELECT_ADDR;
        cyc_data = 8'(cur_bank);
      end
      ST_ACC: begin
        cyc_addr = SRAM_BASE + {3'b000, cur_offset};
        cyc_data = cur_wdata;
        cyc_we   = cur_we;
        cyc_len  = cur_we ? WR_LEN : RD_LEN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      ram_enabled     <= 1'b0;
      bank_valid      <= 1'b0;
      current_bank    <= '0;
      last_grant      <= 1'b1;
      release_pending <= 1'b0;
      port_q          <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
    end else begin
      release_pending <= release_pending | sram.release_req;
      case (state)
        ST_IDLE: begin
          if (launch_valid) begin
            state <= launch;
            if (launch == ST_REL) begin
              release_pending <= sram.release_req;
            end else begin
              port_q     <= grant_port;
              last_grant <= grant_port;
              we_q       <= cur_we;
              addr_q     <= cur_addr;
              wdata_q    <= cur_wdata;
            end
          end
        end
        ST_REL: begin
          if (cyc_done) begin
            ram_enabled <= 1'b0;
            bank_valid  <= 1'b0;
            state       <= ST_DONE;
          end
        end
        ST_EN: begin
          if (cyc_done) begin
            ram_enabled <= 1'b1;
            state       <= launch;
          end
        end
        ST_BANK: begin
          if (cyc_done) begin
            current_bank <= cur_bank;
            bank_valid   <= 1'b1;
            state        <= ST_ACC;
          end
        end
        ST_ACC:  if (cyc_done) state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  cart_bus_cycle u_cycle (
    .clk          (clk_74a),
    .rst_n        (reset_n),
    .start        (launch_valid),
    .we           (cyc_we),
    .addr         (cyc_addr),
    .wdata        (cyc_data),
    .len          (cyc_len),
    .data_in      (cart_tran_bank1_in),
    .done         (cyc_done),
    .rdata        (cyc_rdata),
    .cart_address (cart_address),
    .bank0_out    (bank0_nib),
    .data_out     (cart_tran_bank1_out),
    .dir          (cart_tran_bank1_dir)
  );

  assign cart_tran_bank0_out = bank0_nib;
  assign sram.rdata          = cyc_rdata;
  assign sram.busy           = (state != ST_IDLE);
  assign sram.ack            = (state == ST_ACC && cyc_done) ? (port_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_cart_sram_arbiter.sv
// Directed, table-driven bench for cart_sram_arbiter with a bus-cycle monitor on the cart pins.
module tb_cart_sram_arbiter;

  logic        clk_74a = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cart_address;
  logic [7:4]  bank0;
  logic [7:0]  cart_in = 8'h00;
  logic [7:0]  bank1_out;
  logic        dir;

  int checks = 0;
  int errors = 0;

  always #5 clk_74a = ~clk_74a;

  cart_sram_arbiter_if #(.BANK_BITS(4)) sram();

  cart_sram_arbiter #(
    .READ_CYCLES (16),
    .WRITE_CYCLES(64),
    .BANK_BITS   (4)
  ) dut (
    .clk_74a            (clk_74a),
    .reset_n            (reset_n),
    .sram               (sram),
    .cart_address       (cart_address),
    .cart_tran_bank0_out(bank0),
    .cart_tran_bank1_in (cart_in),
    .cart_tran_bank1_out(bank1_out),
    .cart_tran_bank1_dir(dir)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        dir;
    logic [3:0]  strobe;
    logic [15:0] len;
  } op_t;

  op_t op_q[$];
  op_t cur_op;
  bit  in_strobe = 0;

  // Records each strobe window seen on the pins: address/data/dir at strobe start and its length
  initial forever begin
    @(negedge clk_74a);
    if (!reset_n) begin
      in_strobe = 0;
    end else if (bank0 != 4'b0110) begin
      if (!in_strobe) begin
        in_strobe     = 1;
        cur_op.addr   = cart_address;
        cur_op.data   = bank1_out;
        cur_op.dir    = dir;
        cur_op.strobe = bank0;
        cur_op.len    = 16'd1;
      end else begin
        cur_op.len = cur_op.len + 16'd1;
      end
    end else if (in_strobe) begin
      in_strobe = 0;
      op_q.push_back(cur_op);
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  cin;
    int          lat;
    logic [7:0]  rdata;
    int          n_ops;
    logic [2:0][15:0] op_addr;
    logic [2:0][7:0]  op_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic port, input logic we, input logic [16:0] addr,
                              input logic [7:0] wdata, input logic [7:0] cin, input int lat,
                              input logic [7:0] rdata, input int n_ops,
                              input logic [15:0] a0, input logic [7:0] d0,
                              input logic [15:0] a1, input logic [7:0] d1,
                              input logic [15:0] a2, input logic [7:0] d2);
    vec_t v;
    v.port = port; v.we = we; v.addr = addr; v.wdata = wdata; v.cin = cin;
    v.lat = lat; v.rdata = rdata; v.n_ops = n_ops;
    v.op_addr[0] = a0; v.op_data[0] = d0;
    v.op_addr[1] = a1; v.op_data[1] = d1;
    v.op_addr[2] = a2; v.op_data[2] = d2;
    return v;
  endfunction

  task automatic check_ops(input string tag, input vec_t v, input int base);
    logic wr;
    chk($sformatf("%s_op_count", tag), op_q.size(), base + v.n_ops);
    for (int i = 0; i < v.n_ops && base + i < op_q.size(); i++) begin
      wr = (i < v.n_ops - 1) || v.we;
      chk($sformatf("%s_op%0d_addr", tag, i), op_q[base+i].addr, v.op_addr[i]);
      chk($sformatf("%s_op%0d_strobe", tag, i), op_q[base+i].strobe, wr ? 4'b0011 : 4'b0100);
      chk($sformatf("%s_op%0d_dir", tag, i), op_q[base+i].dir, wr);
      chk($sformatf("%s_op%0d_len", tag, i), op_q[base+i].len, wr ? 64 : 16);
      if (wr) chk($sformatf("%s_op%0d_data", tag, i), op_q[base+i].data, v.op_data[i]);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    bit got;
    op_q.delete();
    sram.we[v.port] = v.we;
    if (v.port) begin
      sram.addr1 = v.addr; sram.wdata1 = v.wdata;
    end else begin
      sram.addr0 = v.addr; sram.wdata0 = v.wdata;
    end
    cart_in = v.cin;
    sram.req[v.port] = 1'b1;
    lat = 0;
    got = 0;
    while (!got && lat < 400) begin
      @(negedge clk_74a);
      lat++;
      if (sram.ack[v.port]) got = 1;
    end
    chk({tag, "_ack_seen"}, got, 1);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rdata"}, sram.rdata, v.rdata);
    sram.req[v.port] = 1'b0;
    @(negedge clk_74a);
    chk({tag, "_ack_pulse"}, sram.ack, 2'b00);
    @(negedge clk_74a);
    check_ops(tag, v, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sram.req = 2'b00;
    sram.release_req = 1'b0;
    repeat (3) @(negedge clk_74a);
    reset_n = 1'b1;
    @(negedge clk_74a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    bit saw;
    vec_t v;

    sram.req = 2'b00; sram.we = 2'b00;
    sram.addr0 = '0; sram.addr1 = '0;
    sram.wdata0 = '0; sram.wdata1 = '0;
    sram.release_req = 1'b0;

    vecs[0] = mk(0, 0, 17'h00005, 8'h00, 8'h5C, 150, 8'h5C, 3,
                 16'h0000, 8'h0A, 16'h4000, 8'h00, 16'hA005, 8'h00);
    vecs[1] = mk(0, 0, 17'h00006, 8'h00, 8'h33, 18, 8'h33, 1,
                 16'hA006, 8'h00, 16'h0000, 8'h00, 16'h0000, 8'h00);
    vecs[2] = mk(0, 0, 17'h02000, 8'h00, 8'h71, 84, 8'h71, 2,
                 16'h4000, 8'h01, 16'hA000, 8'h00, 16'h0000, 8'h00);
    vecs[3] = mk(1, 1, 17'h02010, 8'hA7, 8'hFF, 66, 8'h71, 1,
                 16'hA010, 8'hA7, 16'h0000, 8'h00, 16'h0000, 8'h00);
    vecs[4] = mk(1, 1, 17'h1FFFF, 8'h3C, 8'hFF, 132, 8'h71, 2,
                 16'h4000, 8'h0F, 16'hBFFF, 8'h3C, 16'h0000, 8'h00);
    vecs[5] = mk(0, 0, 17'h1E000, 8'h00, 8'h9E, 18, 8'h9E, 1,
                 16'hA000, 8'h00, 16'h0000, 8'h00, 16'h0000, 8'h00);
    vecs[6] = mk(0, 0, 17'h00000, 8'h00, 8'h12, 84, 8'h12, 2,
                 16'h4000, 8'h00, 16'hA000, 8'h00, 16'h0000, 8'h00);

    do_reset();
    chk("rst_bank0", bank0, 4'b0110);
    chk("rst_dir", dir, 1'b0);
    chk("rst_addr", cart_address, 16'h0000);
    chk("rst_bank1_out", bank1_out, 8'h00);
    chk("rst_ack", sram.ack, 2'b00);
    chk("rst_busy", sram.busy, 1'b0);
    chk("rst_rdata", sram.rdata, 8'h00);

    for (int i = 0; i < 7; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Simultaneous requests from reset: port 0 first, then port 1 write
    do_reset();
    op_q.delete();
    sram.we = 2'b10;
    sram.addr0 = 17'h00005;
    sram.addr1 = 17'h00007;
    sram.wdata1 = 8'hA7;
    cart_in = 8'h5C;
    sram.req = 2'b11;
    lat = 0;
    while (sram.ack == 2'b00 && lat < 400) begin
      @(negedge clk_74a);
      lat++;
    end
    chk("both_first_ack", sram.ack, 2'b01);
    chk("both_first_lat", lat, 150);
    chk("both_first_rdata", sram.rdata, 8'h5C);
    sram.req[0] = 1'b0;
    while (!sram.ack[1] && lat < 600) begin
      @(negedge clk_74a);
      lat++;
    end
    chk("both_second_ack", sram.ack, 2'b10);
    chk("both_second_lat", lat, 218);
    sram.req[1] = 1'b0;
    repeat (2) @(negedge clk_74a);
    chk("both_op_count", op_q.size(), 4);
    if (op_q.size() == 4) begin
      chk("both_op2_addr", op_q[2].addr, 16'hA005);
      chk("both_op2_strobe", op_q[2].strobe, 4'b0100);
      chk("both_op3_addr", op_q[3].addr, 16'hA007);
      chk("both_op3_data", op_q[3].data, 8'hA7);
      chk("both_op3_dir", op_q[3].dir, 1'b1);
      chk("both_op3_strobe", op_q[3].strobe, 4'b0011);
    end

    // Release pulsed while port 1 is mid-write
    op_q.delete();
    sram.we[1] = 1'b1;
    sram.addr1 = 17'h00008;
    sram.wdata1 = 8'h55;
    sram.req[1] = 1'b1;
    lat = 0;
    saw = 0;
    while (!saw && lat < 400) begin
      @(negedge clk_74a);
      lat++;
      sram.release_req = (lat == 30);
      if (sram.ack[1]) saw = 1;
    end
    sram.release_req = 1'b0;
    chk("rel_write_ack", saw, 1);
    chk("rel_write_lat", lat, 66);
    sram.req[1] = 1'b0;
    n = 0;
    while ((op_q.size() < 2 || sram.busy) && n < 400) begin
      @(negedge clk_74a);
      n++;
    end
    chk("rel_finished", n < 400, 1);
    chk("rel_op_count", op_q.size(), 2);
    if (op_q.size() == 2) begin
      chk("rel_op0_addr", op_q[0].addr, 16'hA008);
      chk("rel_op0_data", op_q[0].data, 8'h55);
      chk("rel_op1_addr", op_q[1].addr, 16'h0000);
      chk("rel_op1_data", op_q[1].data, 8'h00);
      chk("rel_op1_strobe", op_q[1].strobe, 4'b0011);
    end
    v = mk(0, 0, 17'h00009, 8'h00, 8'h6D, 150, 8'h6D, 3,
           16'h0000, 8'h0A, 16'h4000, 8'h00, 16'hA009, 8'h00);
    run_vec("post_rel", v);

    // Reset dropped during a read strobe
    sram.we[0] = 1'b0;
    sram.addr0 = 17'h0000A;
    cart_in = 8'hE1;
    sram.req[0] = 1'b1;
    repeat (6) @(negedge clk_74a);
    chk("mid_strobe_bank0", bank0, 4'b0100);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_bank0", bank0, 4'b0110);
    chk("async_rst_dir", dir, 1'b0);
    saw = 0;
    repeat (4) begin
      @(negedge clk_74a);
      saw |= (sram.ack != 2'b00);
    end
    sram.req[0] = 1'b0;
    reset_n = 1'b1;
    repeat (30) begin
      @(negedge clk_74a);
      saw |= (sram.ack != 2'b00);
    end
    chk("async_rst_no_ack", saw, 1'b0);
    chk("async_rst_busy", sram.busy, 1'b0);
    chk("async_rst_rdata", sram.rdata, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
